// File: rtl/fpu_req_ctrl.sv
// Request/response sequencer in front of a fixed-latency fpu.
// Accepts one operation at a time from the core and holds its operands on the fpu inputs.
// Waits out the fpu latency, then returns the result with its tag and flags.
// Also keeps a sticky accumulator of every flag set it has delivered.
module fpu_req_ctrl #(
    parameter int unsigned      C_OP      = 32,
    parameter int unsigned      C_CMD     = 4,
    parameter int unsigned      C_RM      = 3,
    parameter int unsigned      C_TAG     = 5,
    parameter int unsigned      C_LAT     = 2,
    parameter logic [C_CMD-1:0] C_NOP_CMD = 4'h7,
    parameter logic [C_CMD-1:0] C_DIV_CMD = 4'h3
) (
    input  logic             Clk_CI,
    input  logic             Rst_RBI,

    input  logic             Req_Valid_SI,
    output logic             Req_Ready_SO,
    input  logic [C_OP-1:0]  Req_Operand_a_DI,
    input  logic [C_OP-1:0]  Req_Operand_b_DI,
    input  logic [C_RM-1:0]  Req_RM_SI,
    input  logic [C_CMD-1:0] Req_OP_SI,
    input  logic [C_TAG-1:0] Req_Tag_DI,

    output logic             Resp_Valid_SO,
    input  logic             Resp_Ready_SI,
    output logic [C_OP-1:0]  Resp_Result_DO,
    output logic [4:0]       Resp_Flags_DO,
    output logic [C_TAG-1:0] Resp_Tag_DO,

    output logic [C_OP-1:0]  Fpu_Operand_a_DO,
    output logic [C_OP-1:0]  Fpu_Operand_b_DO,
    output logic [C_RM-1:0]  Fpu_RM_SO,
    output logic [C_CMD-1:0] Fpu_OP_SO,
    output logic             Fpu_Enable_SO,
    output logic             Fpu_Stall_SO,
    input  logic [C_OP-1:0]  Fpu_Result_DI,
    input  logic             Fpu_OF_SI,
    input  logic             Fpu_UF_SI,
    input  logic             Fpu_IX_SI,
    input  logic             Fpu_IV_SI,

    input  logic             Flags_Clr_SI,
    output logic [4:0]       Flags_Acc_SO,
    output logic             Busy_SO
);

    localparam int unsigned CntW = $clog2(C_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           r_state;
    logic [CntW-1:0]  r_cnt;
    logic [C_OP-1:0]  r_op_a;
    logic [C_OP-1:0]  r_op_b;
    logic [C_RM-1:0]  r_rm;
    logic [C_CMD-1:0] r_cmd;
    logic [C_TAG-1:0] r_tag;
    logic             r_dz;
    logic [C_OP-1:0]  r_result;
    logic [4:0]       r_flags;
    logic [4:0]       r_acc;

    logic             w_dz;
    logic             w_a_nan;
    logic             w_handshake;

    // Divide of a nonzero, non-NaN dividend by +/-0 raises DZ; the fpu does not report it.
    assign w_a_nan     = (Req_Operand_a_DI[30:23] == 8'hFF) && (Req_Operand_a_DI[22:0] != '0);
    assign w_dz        = (Req_OP_SI == C_DIV_CMD) && (Req_Operand_b_DI[30:0] == '0) &&
                         (Req_Operand_a_DI[30:0] != '0) && !w_a_nan;
    assign w_handshake = (r_state == StResp) && Resp_Ready_SI;

    // Sequencer FSM with holding, result and sticky-flag registers.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rm     <= '0;
            r_cmd    <= '0;
            r_tag    <= '0;
            r_dz     <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_acc    <= '0;
        end else begin
            // Flags delivered on the same edge as a clear are kept.
            if (w_handshake) begin
                r_acc <= (Flags_Clr_SI ? 5'b00000 : r_acc) | r_flags;
            end else if (Flags_Clr_SI) begin
                r_acc <= '0;
            end

            case (r_state)
                StIdle: begin
                    if (Req_Valid_SI) begin
                        r_op_a   <= Req_Operand_a_DI;
                        r_op_b   <= Req_Operand_b_DI;
                        r_rm     <= Req_RM_SI;
                        r_cmd    <= Req_OP_SI;
                        r_tag    <= Req_Tag_DI;
                        r_dz     <= w_dz;
                        r_result <= '0;
                        r_flags  <= '0;
                        if (Req_OP_SI == C_NOP_CMD) begin
                            r_state <= StResp;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= CntW'(C_LAT);
                        end
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CntW'(1)) begin
                        r_result <= Fpu_Result_DI;
                        r_flags  <= {Fpu_IV_SI, r_dz, Fpu_OF_SI, Fpu_UF_SI, Fpu_IX_SI};
                        r_state  <= StResp;
                    end
                end
                StResp: begin
                    if (Resp_Ready_SI) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign Req_Ready_SO     = (r_state == StIdle);
    assign Busy_SO          = (r_state != StIdle);
    assign Resp_Valid_SO    = (r_state == StResp);
    assign Fpu_Enable_SO    = (r_state == StWait);
    assign Fpu_Stall_SO     = 1'b0;
    assign Resp_Result_DO   = r_result;
    assign Resp_Flags_DO    = r_flags;
    assign Resp_Tag_DO      = r_tag;
    assign Fpu_Operand_a_DO = r_op_a;
    assign Fpu_Operand_b_DO = r_op_b;
    assign Fpu_RM_SO        = r_rm;
    assign Fpu_OP_SO        = r_cmd;
    assign Flags_Acc_SO     = r_acc;

endmodule
